// File: rtl/ceespu_pkg.sv
// ============================================================================
// ceespu_pkg : shared op codes, memory size codes and mul/div FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package ceespu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_OR    = 4'd2;
  localparam logic [3:0] ALU_AND   = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SHL   = 4'd5;
  localparam logic [3:0] ALU_SHR   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLTU  = 4'd8;
  localparam logic [3:0] ALU_MUL   = 4'd9;
  localparam logic [3:0] ALU_MULHU = 4'd10;
  localparam logic [3:0] ALU_DIVU  = 4'd11;
  localparam logic [3:0] ALU_REMU  = 4'd12;

  localparam logic [2:0] BR_EQ     = 3'd0;
  localparam logic [2:0] BR_NE     = 3'd1;
  localparam logic [2:0] BR_LT     = 3'd2;
  localparam logic [2:0] BR_GE     = 3'd3;
  localparam logic [2:0] BR_LTU    = 3'd4;
  localparam logic [2:0] BR_GEU    = 3'd5;
  localparam logic [2:0] BR_CARRY  = 3'd6;
  localparam logic [2:0] BR_ALWAYS = 3'd7;

  localparam logic [1:0] SZ_XLEN = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  // Sub-op codes of the sequential unit; bit 0 selects the high half / remainder
  localparam logic [1:0] MD_MUL   = 2'd0;
  localparam logic [1:0] MD_MULHU = 2'd1;
  localparam logic [1:0] MD_DIVU  = 2'd2;
  localparam logic [1:0] MD_REMU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

endpackage

`default_nettype wire

// File: rtl/ceespu_muldiv_seq.sv
// ============================================================================
// ceespu_muldiv_seq : one-bit-per-cycle shift-add multiplier and (with
// CEESPU_EXEC_DIV_EN) restoring divider sharing a hi/lo accumulator.
// Rev 1.0
// ============================================================================
`default_nettype none

module ceespu_muldiv_seq
  import ceespu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic            i_hold,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  md_state_t       r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;

  // Multiply: lo holds the multiplier and shifts out as product bits shift in
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN-1:0] w_mul_hi;
  logic [XLEN-1:0] w_mul_lo;
  logic [XLEN-1:0] w_step_hi;
  logic [XLEN-1:0] w_step_lo;

  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
  assign w_mul_hi  = w_mul_sum[XLEN:1];
  assign w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};

`ifdef CEESPU_EXEC_DIV_EN
  // Divide: lo holds the dividend and collects quotient bits; a zero divisor
  // naturally yields an all-ones quotient and remainder equal to the dividend
  logic [XLEN:0]   w_shift;
  logic [XLEN+1:0] w_diff;
  logic [XLEN-1:0] w_div_hi;
  logic [XLEN-1:0] w_div_lo;
  logic            w_unused_div;

  assign w_shift      = {r_hi, r_lo[XLEN-1]};
  assign w_diff       = {1'b0, w_shift} - {2'b00, r_opnd};
  assign w_div_hi     = w_diff[XLEN+1] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_div_lo     = {r_lo[XLEN-2:0], ~w_diff[XLEN+1]};
  assign w_unused_div = w_diff[XLEN];
  assign w_step_hi    = r_op[1] ? w_div_hi : w_mul_hi;
  assign w_step_lo    = r_op[1] ? w_div_lo : w_mul_lo;
`else
  logic w_unused_op;
  assign w_unused_op = r_op[1];
  assign w_step_hi   = w_mul_hi;
  assign w_step_lo   = w_mul_lo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_op    <= MD_MUL;
      r_hi    <= '0;
      r_lo    <= '0;
      r_opnd  <= '0;
    end else if (i_flush) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_state <= MD_RUN;
            r_cnt   <= CW'(XLEN-1);
            r_op    <= i_op;
            r_hi    <= '0;
            r_opnd  <= i_op[1] ? i_b : i_a;
            r_lo    <= i_op[1] ? i_a : i_b;
          end
        end
        MD_RUN: begin
          r_hi <= w_step_hi;
          r_lo <= w_step_lo;
          if (r_cnt == '0) r_state <= MD_DONE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        MD_DONE: begin
          if (!i_hold) r_state <= MD_IDLE;
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign o_busy   = (r_state != MD_DONE);
  assign o_done   = (r_state == MD_DONE);
  assign o_result = r_op[0] ? r_hi : r_lo;

endmodule

`default_nettype wire

// File: rtl/ceespu_execute_pipe.sv
// ============================================================================
// ceespu_execute_pipe : XLEN-wide execute stage with ALU, branch resolve,
// byte-lane memory control and sequential mul/div. Option: CEESPU_EXEC_DIV_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module ceespu_execute_pipe
  import ceespu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 14
) (
  input  logic              I_clk,
  input  logic              I_rst_n,
  input  logic              I_valid,
  input  logic              I_flush,
  input  logic              I_stall,
  input  logic [3:0]        I_aluop,
  input  logic [1:0]        I_selCin,
  input  logic [2:0]        I_branchop,
  input  logic [XLEN-1:0]   I_dataA,
  input  logic [XLEN-1:0]   I_dataB,
  input  logic [XLEN-1:0]   I_storeData,
  input  logic              I_we,
  input  logic [1:0]        I_selWb,
  input  logic [4:0]        I_regD,
  input  logic              I_memE,
  input  logic              I_memWe,
  input  logic [2:0]        I_selMem,
  input  logic              I_isBranch,
  input  logic              I_prediction,
  input  logic [PC_W-1:0]   I_PC,
  input  logic [PC_W-1:0]   I_branchTarget,
  output logic [XLEN-1:0]   O_memAddress,
  output logic              O_memE,
  output logic [XLEN/8-1:0] O_memWe,
  output logic [XLEN-1:0]   O_storeData,
  output logic              O_busy,
  output logic              O_misaligned,
  output logic              O_branch_taken,
  output logic              O_branch_mispredict,
  output logic [PC_W-1:0]   O_branchTarget,
  output logic              O_valid,
  output logic              O_we,
  output logic [XLEN-1:0]   O_aluResult,
  output logic [1:0]        O_selWb,
  output logic [2:0]        O_selMem,
  output logic [PC_W-1:0]   O_PC,
  output logic [4:0]        O_regD
);

  localparam int LANES = XLEN/8;
  localparam int LBITS = $clog2(LANES);
  localparam int SHW   = $clog2(XLEN);

  logic            r_carry;
  logic            r_valid;
  logic            r_we;
  logic [XLEN-1:0] r_result;
  logic [1:0]      r_selWb;
  logic [2:0]      r_selMem;
  logic [PC_W-1:0] r_pc;
  logic [4:0]      r_regD;

  logic            w_cin;
  logic            w_is_addsub;
  logic [XLEN-1:0] w_bop;
  logic [XLEN:0]   w_sum;
  logic [SHW-1:0]  w_sh;
  logic            w_mcop;
  logic [1:0]      w_md_op;
  logic            w_md_busy;
  logic            w_md_done;
  logic [XLEN-1:0] w_md_result;
  logic [XLEN-1:0] w_result;
  logic            w_cmp;
  logic [XLEN-1:0] w_addr;
  int              w_bytes;
  logic [LBITS-1:0] w_amask;
  logic [LANES-1:0] w_base;

  always_comb begin
    case (I_selCin)
      2'd0:    w_cin = 1'b0;
      2'd1:    w_cin = r_carry;
      2'd2:    w_cin = ~r_carry;
      default: w_cin = 1'b1;
    endcase
  end

  assign w_is_addsub = (I_aluop == ALU_ADD) || (I_aluop == ALU_SUB);
  assign w_bop       = (I_aluop == ALU_SUB) ? ~I_dataB : I_dataB;
  assign w_sum       = {1'b0, I_dataA} + {1'b0, w_bop} + {{XLEN{1'b0}}, w_cin};
  assign w_sh        = I_dataB[SHW-1:0];

`ifdef CEESPU_EXEC_DIV_EN
  assign w_mcop = (I_aluop == ALU_MUL)  || (I_aluop == ALU_MULHU) ||
                  (I_aluop == ALU_DIVU) || (I_aluop == ALU_REMU);
`else
  assign w_mcop = (I_aluop == ALU_MUL)  || (I_aluop == ALU_MULHU);
`endif

  always_comb begin
    case (I_aluop)
      ALU_MULHU: w_md_op = MD_MULHU;
      ALU_DIVU:  w_md_op = MD_DIVU;
      ALU_REMU:  w_md_op = MD_REMU;
      default:   w_md_op = MD_MUL;
    endcase
  end

  ceespu_muldiv_seq #(.XLEN(XLEN)) u_muldiv (
    .clk      (I_clk),
    .rst_n    (I_rst_n),
    .i_start  (I_valid & w_mcop & ~I_flush),
    .i_flush  (I_flush),
    .i_hold   (I_stall),
    .i_op     (w_md_op),
    .i_a      (I_dataA),
    .i_b      (I_dataB),
    .o_busy   (w_md_busy),
    .o_done   (w_md_done),
    .o_result (w_md_result)
  );

  assign O_busy = I_valid & w_mcop & w_md_busy;

  always_comb begin
    w_result = '0;
    case (I_aluop)
      ALU_ADD, ALU_SUB:  w_result = w_sum[XLEN-1:0];
      ALU_OR:            w_result = I_dataA | I_dataB;
      ALU_AND:           w_result = I_dataA & I_dataB;
      ALU_XOR:           w_result = I_dataA ^ I_dataB;
      ALU_SHL:           w_result = I_dataA << w_sh;
      ALU_SHR:           w_result = I_dataA >> w_sh;
      ALU_SRA:           w_result = $signed(I_dataA) >>> w_sh;
      ALU_SLTU:          w_result = {{(XLEN-1){1'b0}}, (I_dataA < I_dataB)};
      ALU_MUL, ALU_MULHU: w_result = w_md_done ? w_md_result : '0;
`ifdef CEESPU_EXEC_DIV_EN
      ALU_DIVU, ALU_REMU: w_result = w_md_done ? w_md_result : '0;
`else
      ALU_DIVU, ALU_REMU: w_result = '1;
`endif
      default:           w_result = '0;
    endcase
  end

  always_comb begin
    case (I_branchop)
      BR_EQ:    w_cmp = (I_dataA == I_dataB);
      BR_NE:    w_cmp = (I_dataA != I_dataB);
      BR_LT:    w_cmp = ($signed(I_dataA) <  $signed(I_dataB));
      BR_GE:    w_cmp = ($signed(I_dataA) >= $signed(I_dataB));
      BR_LTU:   w_cmp = (I_dataA <  I_dataB);
      BR_GEU:   w_cmp = (I_dataA >= I_dataB);
      BR_CARRY: w_cmp = r_carry;
      default:  w_cmp = 1'b1;
    endcase
  end

  assign O_branch_taken      = I_valid & I_isBranch & w_cmp;
  assign O_branch_mispredict = I_valid & I_isBranch & ~I_flush & (w_cmp != I_prediction);
  assign O_branchTarget      = I_prediction ? I_PC : I_branchTarget;

  assign w_addr       = I_dataA + I_dataB;
  assign O_memAddress = w_addr;

  // Access size in bytes and the low address bits that must be zero for it
  always_comb begin
    case (I_selMem[1:0])
      SZ_BYTE: begin w_bytes = 1;     w_amask = '0;          end
      SZ_HALF: begin w_bytes = 2;     w_amask = LBITS'(1);   end
      SZ_WORD: begin w_bytes = 4;     w_amask = LBITS'(3);   end
      default: begin w_bytes = LANES; w_amask = '1;          end
    endcase
  end

  always_comb begin
    w_base = '0;
    for (int i = 0; i < LANES; i++) w_base[i] = (i < w_bytes);
  end

  assign O_misaligned = I_valid & I_memE & (|(w_addr[LBITS-1:0] & w_amask));
  assign O_memE       = I_memE & I_valid & ~I_flush & ~O_misaligned;
  assign O_memWe      = (O_memE & I_memWe) ? (w_base << w_addr[LBITS-1:0]) : '0;

  always_comb begin
    O_storeData = '0;
    for (int i = 0; i < LANES; i++) begin
      case (I_selMem[1:0])
        SZ_BYTE: O_storeData[8*i +: 8] = I_storeData[7:0];
        SZ_HALF: O_storeData[8*i +: 8] = I_storeData[8*(i%2) +: 8];
        SZ_WORD: O_storeData[8*i +: 8] = I_storeData[8*(i%4) +: 8];
        default: O_storeData[8*i +: 8] = I_storeData[8*i +: 8];
      endcase
    end
  end

  // Flush inserts a bubble even while stalled; stall otherwise freezes everything
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_carry  <= 1'b0;
      r_valid  <= 1'b0;
      r_we     <= 1'b0;
      r_result <= '0;
      r_selWb  <= '0;
      r_selMem <= '0;
      r_pc     <= '0;
      r_regD   <= '0;
    end else begin
      if (I_flush) begin
        r_valid <= 1'b0;
        r_we    <= 1'b0;
      end else if (!I_stall) begin
        r_valid  <= I_valid & ~O_busy;
        r_we     <= I_we & I_valid & ~O_busy;
        r_result <= w_result;
        r_selWb  <= I_selWb;
        r_selMem <= I_selMem;
        r_pc     <= I_PC;
        r_regD   <= I_regD;
      end
      if (I_valid && !I_flush && !I_stall && w_is_addsub) r_carry <= w_sum[XLEN];
    end
  end

  assign O_valid     = r_valid;
  assign O_we        = r_we;
  assign O_aluResult = r_result;
  assign O_selWb     = r_selWb;
  assign O_selMem    = r_selMem;
  assign O_PC        = r_pc;
  assign O_regD      = r_regD;

endmodule

`default_nettype wire

// File: tb/tb_ceespu_execute_pipe.sv
// ============================================================================
// tb_ceespu_execute_pipe : directed vectors for the execute stage (XLEN=32)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ceespu_execute_pipe;
  import ceespu_pkg::*;

  localparam int XLEN = 32;
  localparam int PC_W = 14;

  logic              I_clk = 1'b0;
  logic              I_rst_n;
  logic              I_valid, I_flush, I_stall;
  logic [3:0]        I_aluop;
  logic [1:0]        I_selCin;
  logic [2:0]        I_branchop;
  logic [XLEN-1:0]   I_dataA, I_dataB, I_storeData;
  logic              I_we;
  logic [1:0]        I_selWb;
  logic [4:0]        I_regD;
  logic              I_memE, I_memWe;
  logic [2:0]        I_selMem;
  logic              I_isBranch, I_prediction;
  logic [PC_W-1:0]   I_PC, I_branchTarget;
  logic [XLEN-1:0]   O_memAddress;
  logic              O_memE;
  logic [XLEN/8-1:0] O_memWe;
  logic [XLEN-1:0]   O_storeData;
  logic              O_busy, O_misaligned, O_branch_taken, O_branch_mispredict;
  logic [PC_W-1:0]   O_branchTarget;
  logic              O_valid, O_we;
  logic [XLEN-1:0]   O_aluResult;
  logic [1:0]        O_selWb;
  logic [2:0]        O_selMem;
  logic [PC_W-1:0]   O_PC;
  logic [4:0]        O_regD;

  int n_checks = 0;
  int n_errors = 0;

  always #5 I_clk = ~I_clk;

  ceespu_execute_pipe #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_valid(I_valid), .I_flush(I_flush), .I_stall(I_stall),
    .I_aluop(I_aluop), .I_selCin(I_selCin), .I_branchop(I_branchop),
    .I_dataA(I_dataA), .I_dataB(I_dataB), .I_storeData(I_storeData),
    .I_we(I_we), .I_selWb(I_selWb), .I_regD(I_regD),
    .I_memE(I_memE), .I_memWe(I_memWe), .I_selMem(I_selMem),
    .I_isBranch(I_isBranch), .I_prediction(I_prediction), .I_PC(I_PC), .I_branchTarget(I_branchTarget),
    .O_memAddress(O_memAddress), .O_memE(O_memE), .O_memWe(O_memWe), .O_storeData(O_storeData),
    .O_busy(O_busy), .O_misaligned(O_misaligned), .O_branch_taken(O_branch_taken),
    .O_branch_mispredict(O_branch_mispredict), .O_branchTarget(O_branchTarget),
    .O_valid(O_valid), .O_we(O_we), .O_aluResult(O_aluResult), .O_selWb(O_selWb),
    .O_selMem(O_selMem), .O_PC(O_PC), .O_regD(O_regD)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge I_clk);
    #1;
  endtask

  task automatic idle_inputs;
    I_valid = 1'b0; I_flush = 1'b0; I_stall = 1'b0;
    I_aluop = ALU_OR; I_selCin = 2'd0; I_branchop = BR_EQ;
    I_dataA = '0; I_dataB = '0; I_storeData = '0;
    I_we = 1'b0; I_selWb = 2'd0; I_regD = 5'd0;
    I_memE = 1'b0; I_memWe = 1'b0; I_selMem = 3'd0;
    I_isBranch = 1'b0; I_prediction = 1'b0;
    I_PC = 14'h0123; I_branchTarget = 14'h0ABC;
  endtask

  task automatic alu(input string tag, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [1:0] cin, input logic [31:0] exp);
    idle_inputs();
    I_valid = 1'b1; I_we = 1'b1; I_aluop = op; I_dataA = a; I_dataB = b;
    I_selCin = cin; I_regD = 5'd9;
    #1;
    check({tag, " busy"}, 64'(O_busy), 64'd0);
    tick();
    check(tag, 64'(O_aluResult), 64'(exp));
    check({tag, " valid"}, 64'(O_valid), 64'd1);
    check({tag, " regD"}, 64'(O_regD), 64'd9);
  endtask

  task automatic mc(input string tag, input logic [3:0] op, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] exp, input int stall_cycles);
    int n;
    idle_inputs();
    I_valid = 1'b1; I_we = 1'b1; I_aluop = op; I_dataA = a; I_dataB = b;
    #1;
    n = 0;
    while (O_busy && n < 100) begin
      n++;
      tick();
    end
    check({tag, " busy cycles"}, 64'(n), 64'd33);
    check({tag, " valid at done"}, 64'(O_valid), 64'd0);
    if (stall_cycles > 0) begin
      I_stall = 1'b1;
      for (int k = 0; k < stall_cycles; k++) begin
        tick();
        check({tag, " stall hold"}, 64'(O_valid), 64'd0);
        check({tag, " stall busy"}, 64'(O_busy), 64'd0);
      end
      I_stall = 1'b0;
    end
    tick();
    check(tag, 64'(O_aluResult), 64'(exp));
    check({tag, " valid"}, 64'(O_valid), 64'd1);
    check({tag, " we"}, 64'(O_we), 64'd1);
    idle_inputs();
  endtask

  task automatic br(input string tag, input logic [2:0] bop, input logic [31:0] a,
                    input logic [31:0] b, input logic pred, input logic fl,
                    input logic exp_taken, input logic exp_mis, input logic [13:0] exp_tgt);
    idle_inputs();
    I_valid = 1'b1; I_isBranch = 1'b1; I_branchop = bop; I_dataA = a; I_dataB = b;
    I_prediction = pred; I_flush = fl;
    #1;
    check({tag, " taken"}, 64'(O_branch_taken), 64'(exp_taken));
    check({tag, " mispredict"}, 64'(O_branch_mispredict), 64'(exp_mis));
    check({tag, " target"}, 64'(O_branchTarget), 64'(exp_tgt));
    tick();
  endtask

  task automatic mem(input string tag, input logic [1:0] sz, input logic st,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                     input logic [3:0] exp_we, input logic exp_e, input logic exp_mis,
                     input logic [31:0] exp_sd, input logic [31:0] exp_addr);
    idle_inputs();
    I_valid = 1'b1; I_memE = 1'b1; I_memWe = st; I_selMem = {1'b0, sz};
    I_dataA = a; I_dataB = b; I_storeData = sd;
    #1;
    check({tag, " memWe"}, 64'(O_memWe), 64'(exp_we));
    check({tag, " memE"}, 64'(O_memE), 64'(exp_e));
    check({tag, " misaligned"}, 64'(O_misaligned), 64'(exp_mis));
    check({tag, " storeData"}, 64'(O_storeData), 64'(exp_sd));
    check({tag, " address"}, 64'(O_memAddress), 64'(exp_addr));
    tick();
  endtask

  initial begin
    I_rst_n = 1'b0;
    idle_inputs();
    #12;
    check("reset valid", 64'(O_valid), 64'd0);
    check("reset we", 64'(O_we), 64'd0);
    check("reset result", 64'(O_aluResult), 64'd0);
    check("reset PC", 64'(O_PC), 64'd0);
    check("reset regD", 64'(O_regD), 64'd0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
    tick();
    br("reset carry", BR_CARRY, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0ABC);

    // Carry chain: set, consume as +1, then consume inverted
    alu("add wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0);
    check("add wrap PC", 64'(O_PC), 64'h123);
    alu("add cin carry", ALU_ADD, 32'd0, 32'd0, 2'd1, 32'd1);
    alu("add cin ncarry", ALU_ADD, 32'd0, 32'd0, 2'd2, 32'd1);
    alu("add", ALU_ADD, 32'h10, 32'h20, 2'd0, 32'h30);
    alu("sub", ALU_SUB, 32'd5, 32'd3, 2'd3, 32'd2);
    br("carry after sub", BR_CARRY, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 14'h0123);
    alu("or", ALU_OR, 32'hF0, 32'h0F, 2'd0, 32'hFF);
    alu("and", ALU_AND, 32'hFF00, 32'h0FF0, 2'd0, 32'h0F00);
    alu("xor", ALU_XOR, 32'hFFFF, 32'h00FF, 2'd0, 32'hFF00);
    alu("shl masked", ALU_SHL, 32'd1, 32'h21, 2'd0, 32'd2);
    alu("shr", ALU_SHR, 32'h8000_0000, 32'd4, 2'd0, 32'h0800_0000);
    alu("sra", ALU_SRA, 32'h8000_0000, 32'd4, 2'd0, 32'hF800_0000);
    alu("sltu true", ALU_SLTU, 32'd1, 32'd2, 2'd0, 32'd1);
    alu("sltu false", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0);
    alu("op13", 4'd13, 32'd5, 32'd6, 2'd0, 32'd0);

    br("beq", BR_EQ, 32'd7, 32'd7, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0ABC);
    br("beq flushed", BR_EQ, 32'd7, 32'd7, 1'b0, 1'b1, 1'b1, 1'b0, 14'h0ABC);
    br("beq predicted", BR_EQ, 32'd7, 32'd7, 1'b1, 1'b0, 1'b1, 1'b0, 14'h0123);
    br("blt signed", BR_LT, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1'b1, 14'h0ABC);
    br("bltu", BR_LTU, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b0, 1'b0, 14'h0ABC);

    mem("sb", SZ_BYTE, 1'b1, 32'h1001, 32'd2, 32'hAB, 4'b1000, 1'b1, 1'b0, 32'hABAB_ABAB, 32'h1003);
    mem("sh misaligned", SZ_HALF, 1'b1, 32'h1001, 32'd0, 32'hABCD, 4'b0000, 1'b0, 1'b1, 32'hABCD_ABCD, 32'h1001);
    mem("sh", SZ_HALF, 1'b1, 32'h1000, 32'd2, 32'hABCD, 4'b1100, 1'b1, 1'b0, 32'hABCD_ABCD, 32'h1002);
    mem("sw", SZ_WORD, 1'b1, 32'h1000, 32'd4, 32'h1234_5678, 4'b1111, 1'b1, 1'b0, 32'h1234_5678, 32'h1004);
    mem("sx misaligned", SZ_XLEN, 1'b1, 32'h1002, 32'd0, 32'h1, 4'b0000, 1'b0, 1'b1, 32'h1, 32'h1002);
    mem("lb", SZ_BYTE, 1'b0, 32'h1003, 32'd0, 32'hAB, 4'b0000, 1'b1, 1'b0, 32'hABAB_ABAB, 32'h1003);

    mc("mul 7x6", ALU_MUL, 32'd7, 32'd6, 32'd42, 0);
    mc("mulhu stalled", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    mc("mul low", ALU_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 0);
`ifdef CEESPU_EXEC_DIV_EN
    mc("divu by zero", ALU_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 0);
    mc("remu", ALU_REMU, 32'd100, 32'd7, 32'd2, 0);
    mc("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 0);
`else
    alu("divu single", ALU_DIVU, 32'd100, 32'd0, 2'd0, 32'hFFFF_FFFF);
    alu("remu single", ALU_REMU, 32'd100, 32'd7, 2'd0, 32'hFFFF_FFFF);
`endif

    // Flushed ADD must neither deliver nor touch the carry
    alu("carry set", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 2'd0, 32'd0);
    idle_inputs();
    I_valid = 1'b1; I_we = 1'b1; I_aluop = ALU_ADD; I_flush = 1'b1;
    tick();
    check("flush add valid", 64'(O_valid), 64'd0);
    check("flush add we", 64'(O_we), 64'd0);

    // Flush a running multiply at t+10
    idle_inputs();
    I_valid = 1'b1; I_we = 1'b1; I_aluop = ALU_MUL; I_dataA = 32'd3; I_dataB = 32'd3;
    #1;
    check("flush mul busy", 64'(O_busy), 64'd1);
    repeat (10) tick();
    I_flush = 1'b1;
    tick();
    check("flush run valid", 64'(O_valid), 64'd0);
    check("flush run we", 64'(O_we), 64'd0);
    br("carry kept", BR_CARRY, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 14'h0123);
    mc("mul after flush", ALU_MUL, 32'd2, 32'd5, 32'd10, 0);

    // Async reset in the middle of a multiply
    idle_inputs();
    I_valid = 1'b1; I_we = 1'b1; I_aluop = ALU_MUL; I_dataA = 32'd9; I_dataB = 32'd9;
    repeat (5) tick();
    I_rst_n = 1'b0;
    #1;
    check("rst mid run valid", 64'(O_valid), 64'd0);
    check("rst mid run result", 64'(O_aluResult), 64'd0);
    idle_inputs();
    #2;
    I_rst_n = 1'b1;
    tick();
    mc("mul after reset", ALU_MUL, 32'd11, 32'd13, 32'd143, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
